// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM encoding and
// the bit-counter width rule.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold 0..width, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Mirror of the full-adder cell used by the ripple-carry adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first over WIDTH cycles, with a
// start/done handshake and registered result, borrow-out and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one bit per cycle through the full-subtractor cell
// DONE  | done pulse; a new start is accepted here for back-to-back use
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_next;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // br here is the borrow into the MSB; V compares it with borrow-out.
            D     <= res_next;
            Bout  <= br_next;
            V     <= br ^ br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
